// File: rtl/click_rr_arbiter.sv
// click_rr_arbiter
//   Round-robin arbiter that shares one 2-phase (transition-signalling) click
//   pipeline among N_CH producers. One token is in flight at a time. A
//   producer is acknowledged only after the pipeline head has acknowledged the
//   forwarded token.
//
//   Optional build macro: CLICK_ARB_SYNC_EN
//     defined   : in_req and out_ack pass through 2-flop synchronizers, so the
//                 click-domain neighbours may be truly asynchronous. This adds
//                 2 cycles to each handshake latency.
//     undefined : in_req and out_ack must be synchronous to clk.
//   in_data/out_data are never synchronized. The 2-phase bundling keeps them
//   stable while a token is pending.
module click_rr_arbiter #(
   parameter int N_CH = 4,
   parameter int DW   = 8,
   parameter int CW   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH-1:0]         in_req,
   output logic [N_CH-1:0]         in_ack,
   input  logic [N_CH*DW-1:0]      in_data,
   output logic                    out_req,
   input  logic                    out_ack,
   output logic [DW-1:0]           out_data,
   output logic [$clog2(N_CH)-1:0] grant_id,
   output logic                    busy,
   output logic [CW-1:0]           xfer_cnt
);

   localparam int IW = $clog2(N_CH);
   // Wide enough to hold last+1+k (at most 2*N_CH-1) without overflow.
   localparam int SW = IW + 2;
   localparam logic [SW-1:0] L_NCH = SW'(N_CH);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

   state_t          r_state;
   logic [N_CH-1:0] r_in_ack;
   logic            r_out_req;
   logic [DW-1:0]   r_out_data;
   logic [IW-1:0]   r_grant;
   logic [IW-1:0]   r_last;
   logic            r_busy;
   logic [CW-1:0]   r_xfer_cnt;

   logic [N_CH-1:0] w_req;
   logic            w_out_ack;
   logic [N_CH-1:0] w_pend;
   logic [SW-1:0]   w_sum      [N_CH];
   logic [IW-1:0]   w_cand     [N_CH];
   logic [N_CH-1:0] w_rot_pend;
   logic [DW-1:0]   w_ch_data  [N_CH];
   logic [IW-1:0]   w_win;
   logic            w_any;

`ifdef CLICK_ARB_SYNC_EN
   logic [N_CH-1:0] r_req_s1;
   logic [N_CH-1:0] r_req_s2;
   logic            r_ack_s1;
   logic            r_ack_s2;

   // Two-flop synchronizers that bring the asynchronous handshake inputs into clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_s1 <= '0;
         r_req_s2 <= '0;
         r_ack_s1 <= 1'b0;
         r_ack_s2 <= 1'b0;
      end else begin
         r_req_s1 <= in_req;
         r_req_s2 <= r_req_s1;
         r_ack_s1 <= out_ack;
         r_ack_s2 <= r_ack_s1;
      end
   end

   assign w_req     = r_req_s2;
   assign w_out_ack = r_ack_s2;
`else
   assign w_req     = in_req;
   assign w_out_ack = out_ack;
`endif

   // Per-channel pending flags, data slices and the rotated scan order.
   // Slot gi of the rotated view is channel (last + 1 + gi) mod N_CH.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign w_pend[gi]     = w_req[gi] ^ r_in_ack[gi];
      assign w_ch_data[gi]  = in_data[gi*DW +: DW];
      assign w_sum[gi]      = {2'b00, r_last} + SW'(gi + 1);
      assign w_cand[gi]     = (w_sum[gi] >= L_NCH) ? IW'(w_sum[gi] - L_NCH)
                                                   : IW'(w_sum[gi]);
      assign w_rot_pend[gi] = w_pend[w_cand[gi]];
   end

   // Select the first pending channel after the previous winner.
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (w_rot_pend[k]) begin
            w_win = w_cand[k];
            w_any = 1'b1;
         end
      end
   end

   // Handshake FSM: grant and forward, wait for the pipeline ack, then one bubble cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_in_ack   <= '0;
         r_out_req  <= 1'b0;
         r_out_data <= '0;
         r_grant    <= '0;
         r_last     <= IW'(N_CH - 1);
         r_busy     <= 1'b0;
         r_xfer_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant    <= w_win;
                  r_out_data <= w_ch_data[w_win];
                  r_out_req  <= ~r_out_req;
                  r_busy     <= 1'b1;
                  r_state    <= S_SEND;
               end
            end
            S_SEND: begin
               // An out_ack toggle outside SEND is never looked at. Only
               // equality while waiting here completes the token.
               if (w_out_ack == r_out_req) begin
                  r_in_ack[r_grant] <= ~r_in_ack[r_grant];
                  r_last            <= r_grant;
                  r_xfer_cnt        <= r_xfer_cnt + CW'(1);
                  r_state           <= S_DONE;
               end
            end
            S_DONE: begin
               // Bubble cycle: the new in_ack is visible before the next arbitration.
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ack   = r_in_ack;
   assign out_req  = r_out_req;
   assign out_data = r_out_data;
   assign grant_id = r_grant;
   assign busy     = r_busy;
   assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_click_rr_arbiter.sv
// tb_click_rr_arbiter
//   Directed bench for click_rr_arbiter. A cycle-level behavioural model keeps
//   a rotating priority queue, and one compare process checks the DUT against
//   it after every rising edge. The directed scenarios also carry hand-computed
//   literal expectations. Build with CLICK_ARB_SYNC_EN to exercise the
//   synchronized variant.
module tb_click_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int CW = 8;
   localparam int GW = $clog2(N);
`ifdef CLICK_ARB_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    in_req = '0;
   logic [N-1:0]    in_ack;
   logic [N*DW-1:0] in_data = '0;
   logic            out_req;
   logic            out_ack = 1'b0;
   logic [DW-1:0]   out_data;
   logic [GW-1:0]   grant_id;
   logic            busy;
   logic [CW-1:0]   xfer_cnt;

   int checks = 0;
   int failures = 0;

   logic         auto_ack = 1'b0;
   logic [N-1:0] regen = '0;
   int           grants[$];
   int           datas[$];
   logic         mon_prev = 1'b0;

   click_rr_arbiter #(.N_CH(N), .DW(DW), .CW(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_req   (in_req),
      .in_ack   (in_ack),
      .in_data  (in_data),
      .out_req  (out_req),
      .out_ack  (out_ack),
      .out_data (out_data),
      .grant_id (grant_id),
      .busy     (busy),
      .xfer_cnt (xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [N-1:0]  m_ack, m_rq1, m_rq2, eff_req;
   logic          m_oreq, m_oa1, m_oa2, eff_oack;
   logic [DW-1:0] m_odata;
   logic [GW-1:0] m_gid;
   logic          m_busy, m_flight, m_bubble;
   logic [CW-1:0] m_cnt;
   logic [GW-1:0] m_prio[$];

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_ack = '0; m_rq1 = '0; m_rq2 = '0;
         m_oreq = 1'b0; m_oa1 = 1'b0; m_oa2 = 1'b0;
         m_odata = '0; m_gid = '0; m_busy = 1'b0; m_cnt = '0;
         m_flight = 1'b0; m_bubble = 1'b0;
         m_prio.delete();
         for (int i = 0; i < N; i++) m_prio.push_back(GW'(i));
      end else begin
`ifdef CLICK_ARB_SYNC_EN
         eff_req = m_rq2; eff_oack = m_oa2;
         m_rq2 = m_rq1; m_rq1 = in_req;
         m_oa2 = m_oa1; m_oa1 = out_ack;
`else
         eff_req = in_req; eff_oack = out_ack;
`endif
         if (m_bubble) begin
            m_bubble = 1'b0;
            m_busy = 1'b0;
         end else if (m_flight) begin
            if (eff_oack == m_oreq) begin
               m_ack[m_gid] = ~m_ack[m_gid];
               m_cnt = m_cnt + 1'b1;
               // rotate so the winner sits at the back (lowest priority)
               while (m_prio[N-1] != m_gid) m_prio.push_back(m_prio.pop_front());
               m_flight = 1'b0;
               m_bubble = 1'b1;
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               if (!m_flight && (eff_req[m_prio[k]] ^ m_ack[m_prio[k]])) begin
                  m_gid = m_prio[k];
                  m_odata = in_data[m_gid*DW +: DW];
                  m_oreq = ~m_oreq;
                  m_busy = 1'b1;
                  m_flight = 1'b1;
               end
            end
         end
      end
   end

   // Compare process: model vs DUT after every edge, and grant log on out_req toggles.
   initial forever begin
      @(posedge clk);
      #1;
      chk("model_in_ack", in_ack, m_ack);
      chk("model_out_req", out_req, m_oreq);
      chk("model_out_data", out_data, m_odata);
      chk("model_grant_id", grant_id, m_gid);
      chk("model_busy", busy, m_busy);
      chk("model_xfer_cnt", xfer_cnt, m_cnt);
      if (rst_n && (out_req !== mon_prev)) begin
         grants.push_back(int'(grant_id));
         datas.push_back(int'(out_data));
      end
      mon_prev = out_req;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      if (auto_ack) out_ack = out_req;
      for (int i = 0; i < N; i++)
         if (regen[i] && (in_req[i] == in_ack[i])) in_req[i] = ~in_req[i];
   endtask

   task automatic edges(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_cnt(input int n, input int bound, input string name);
      int c;
      c = 0;
      do begin
         tick();
         edges(1);
         c++;
      end while ((xfer_cnt != CW'(n)) && (c < bound));
      chk(name, xfer_cnt, n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_req = '0; out_ack = 1'b0; auto_ack = 1'b0; regen = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int errs, n1, n3;

      // 1: reset with random inputs, then idle
      repeat (3) begin
         @(negedge clk);
         in_req = N'($urandom); out_ack = 1'($urandom); in_data = {$urandom};
      end
      edges(1);
      chk("s1_rst_in_ack", in_ack, 0);
      chk("s1_rst_out_req", out_req, 0);
      chk("s1_rst_out_data", out_data, 0);
      chk("s1_rst_grant", grant_id, 0);
      chk("s1_rst_busy", busy, 0);
      chk("s1_rst_xfer", xfer_cnt, 0);
      @(negedge clk);
      in_req = '0; out_ack = 1'b0; rst_n = 1'b1;
      repeat (20) begin
         edges(1);
         chk("s1_idle_out_req", out_req, 0);
      end

      // 2: single token on ch2
      @(negedge clk);
      in_data[2*DW +: DW] = 8'hA5; in_req[2] = 1'b1;
      edges(LAT);
      chk("s2_out_req", out_req, 1);
      chk("s2_out_data", out_data, 8'hA5);
      chk("s2_grant", grant_id, 2);
      chk("s2_busy", busy, 1);
      @(negedge clk);
      out_ack = 1'b1;
      edges(LAT);
      chk("s2_in_ack", in_ack, 4'b0100);
      chk("s2_xfer", xfer_cnt, 1);
      edges(1);
      chk("s2_busy_clear", busy, 0);
      // spurious out_ack toggle while idle is ignored
      @(negedge clk);
      out_ack = 1'b0;
      edges(5);
      chk("s2_spur_out_req", out_req, 1);
      chk("s2_spur_xfer", xfer_cnt, 1);
      @(negedge clk);
      in_data[0 +: DW] = 8'h3C; in_req[0] = 1'b1;
      edges(LAT);
      chk("s2_spur_next_req", out_req, 0);
      chk("s2_spur_next_grant", grant_id, 0);
      chk("s2_spur_next_data", out_data, 8'h3C);
      edges(1);
      chk("s2_spur_in_ack", in_ack, 4'b0101);
      chk("s2_spur_xfer2", xfer_cnt, 2);

      // 3: all channels pending at once
      do_reset();
      grants.delete(); datas.delete();
      @(negedge clk);
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(8'h10 + i);
      in_req = 4'hF; auto_ack = 1'b1;
      wait_cnt(4, 200, "s3_xfer4");
      chk("s3_ngrants", grants.size(), 4);
      for (int k = 0; (k < grants.size()) && (k < 4); k++) begin
         chk("s3_grant_order", grants[k], k);
         chk("s3_data_order", datas[k], 8'h10 + k);
      end
      chk("s3_in_ack", in_ack, 4'hF);

      // 4: ch1 and ch3 re-request continuously; alternation, then counter wrap
      do_reset();
      grants.delete(); datas.delete();
      @(negedge clk);
      in_data[1*DW +: DW] = 8'h11; in_data[3*DW +: DW] = 8'h33;
      regen = 4'b1010; auto_ack = 1'b1;
      wait_cnt(100, 1500, "s4_xfer100");
      errs = 0; n1 = 0; n3 = 0;
      for (int k = 0; (k < grants.size()) && (k < 100); k++) begin
         if (grants[k] != ((k % 2 == 0) ? 1 : 3)) errs++;
         if (grants[k] == 1) n1++;
         if (grants[k] == 3) n3++;
      end
      chk("s4_alternate_errs", errs, 0);
      chk("s4_ch1_tokens", n1, 50);
      chk("s4_ch3_tokens", n3, 50);
      wait_cnt(0, 2500, "s4_wrap_to_0");
      chk("s4_wrap_ngrants", grants.size(), 256);

      // 5: reset pulse while a token waits for the pipeline ack
      do_reset();
      @(negedge clk);
      in_data[1*DW +: DW] = 8'h77; in_req[1] = 1'b1; auto_ack = 1'b1;
      wait_cnt(1, 50, "s5_xfer1");
      auto_ack = 1'b0;
      @(negedge clk);
      in_data[2*DW +: DW] = 8'h22; in_req[2] = 1'b1;
      edges(4);
      chk("s5_pre_busy", busy, 1);
      chk("s5_pre_grant", grant_id, 2);
      chk("s5_pre_out_req", out_req, 0);
      chk("s5_pre_in_ack", in_ack, 4'b0010);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("s5_async_in_ack", in_ack, 0);
      chk("s5_async_xfer", xfer_cnt, 0);
      chk("s5_async_busy", busy, 0);
      chk("s5_async_grant", grant_id, 0);
      chk("s5_async_data", out_data, 0);
      chk("s5_async_out_req", out_req, 0);
      @(negedge clk);
      in_req = '0; out_ack = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      in_data[0 +: DW] = 8'hC0; in_data[3*DW +: DW] = 8'h3F;
      in_req = 4'b1001;
      edges(LAT);
      chk("s5_restart_req", out_req, 1);
      chk("s5_restart_grant", grant_id, 0);
      chk("s5_restart_data", out_data, 8'hC0);
      auto_ack = 1'b1;
      wait_cnt(2, 100, "s5_restart_xfer2");
      chk("s5_restart_in_ack", in_ack, 4'b1001);
      chk("s5_restart_last_data", out_data, 8'h3F);

      auto_ack = 1'b0;
      edges(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
